// File: rtl/connect4_board_pkg.sv
// Shared definitions for the Connect-4 board controller: board geometry,
// cell codes, FSM encoding and the (col,row) -> grid bit mapping.
package connect4_board_pkg;

  localparam int ROWS        = 6;
  localparam int COLS        = 7;
  localparam int GRID_W      = 2 * ROWS * COLS;
  localparam int NUM_WINDOWS = 69;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HUMAN = 2'b01,
    AI    = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    WAIT_HUMAN = 2'd0,
    WAIT_AI    = 2'd1,
    SCAN       = 2'd2,
    OVER       = 2'd3
  } state_e;

  // Column 0 sits in the most significant pair of each row, row 0 in the lowest bits.
  function automatic int cellMsb(input int c, input int r);
    return (2 * COLS - 1) - 2 * c + 2 * COLS * r;
  endfunction

endpackage

// File: rtl/connect4_board_if.sv
// Move requests in, board state and game status out, for the Connect-4 board controller.
interface connect4_board_if;
  import connect4_board_pkg::*;

  logic                sw;
  logic                new_game;
  logic                human_valid;
  logic [2:0]          human_col;
  logic                move;
  logic [6:0]          opt;
  logic [GRID_W-1:0]   grid;
  logic [3*COLS-1:0]   column_counts;
  logic                player;
  logic                busy;
  logic                game_over;
  logic [1:0]          winner;
  logic                illegal;

  modport master (
    output sw, new_game, human_valid, human_col, move, opt,
    input  grid, column_counts, player, busy, game_over, winner, illegal
  );

  modport slave (
    input  sw, new_game, human_valid, human_col, move, opt,
    output grid, column_counts, player, busy, game_over, winner, illegal
  );

endinterface

// File: rtl/connect4_board_win_scan.sv
// Sequential four-in-a-row detector: walks the 69 board windows one per cycle
// while start is held high, flagging a window whose four cells all match colour.
module win_scan
  import connect4_board_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GRID_W-1:0] grid,
  input  logic [1:0]        colour,
  input  logic              start,
  output logic              hit,
  output logic              done
);

  logic [6:0] idx_q, idx_d;
  logic [1:0] cells [COLS][ROWS];
  logic [6:0] k;
  logic [2:0] col0, row0;
  logic [1:0] dir;
  logic [2:0] cc [4];
  logic [2:0] rr [4];
  logic       match;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign cells[c][r] = grid[cellMsb(c, r) -: 2];
    end
  end

  // Window order: horizontal, vertical, rising diagonal, falling diagonal (falling starts high and steps down).
  always_comb begin
    k    = '0;
    col0 = '0;
    row0 = '0;
    dir  = 2'd0;
    if (idx_q < 7'd24) begin
      k    = idx_q;
      col0 = {1'b0, k[1:0]};
      row0 = k[4:2];
      dir  = 2'd0;
    end else if (idx_q < 7'd45) begin
      k    = idx_q - 7'd24;
      col0 = 3'(k / 7'd3);
      row0 = 3'(k % 7'd3);
      dir  = 2'd1;
    end else if (idx_q < 7'd57) begin
      k    = idx_q - 7'd45;
      col0 = {1'b0, k[1:0]};
      row0 = {1'b0, k[3:2]};
      dir  = 2'd2;
    end else begin
      k    = idx_q - 7'd57;
      col0 = {1'b0, k[1:0]};
      row0 = 3'd3 + {1'b0, k[3:2]};
      dir  = 2'd3;
    end

    match = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cc[i] = col0;
      rr[i] = row0;
      unique case (dir)
        2'd0: cc[i] = col0 + 3'(i);
        2'd1: rr[i] = row0 + 3'(i);
        2'd2: begin cc[i] = col0 + 3'(i); rr[i] = row0 + 3'(i); end
        default: begin cc[i] = col0 + 3'(i); rr[i] = row0 - 3'(i); end
      endcase
      if (cells[cc[i]][rr[i]] != colour) match = 1'b0;
    end
  end

  always_comb begin
    hit   = start && match;
    done  = start && (idx_q == 7'(NUM_WINDOWS - 1));
    idx_d = (start && !hit && !done) ? idx_q + 7'd1 : 7'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

endmodule

// File: rtl/connect4_board.sv
// Connect-4 board controller: validates human / minimax drops, maintains the
// grid and column fill counts, and runs a win scan after every placed piece.
module connect4_board #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  connect4_board_if.slave  bus
);
  import connect4_board_pkg::*;

  logic [1:0]        cells_q [COLS][ROWS];
  logic [1:0]        cells_d [COLS][ROWS];
  logic [2:0]        counts_q [COLS];
  logic [2:0]        counts_d [COLS];
  state_e            state_q, state_d;
  logic              player_q, player_d;
  logic              gameOver_q, gameOver_d;
  logic              illegal_q, illegal_d;
  logic [1:0]        winner_q, winner_d;

  logic              doPlace;
  logic [2:0]        placeCol;
  logic [1:0]        placeColour;
  logic [1:0]        moverColour;
  logic              humanOk, aiOk, allFull;
  logic              scanHit, scanDone;
  logic [2:0]        fallbackCol, aiCol;
  logic [6:0]        optMod, optRow;
  logic [GRID_W-1:0] gridPacked;

  // Decode the minimax bit index back to (col,row) and pick the fallback column.
  always_comb begin
    optMod      = bus.opt % 7'd14;
    optRow      = bus.opt / 7'd14;
    aiCol       = 3'((7'd13 - optMod) >> 1);
    aiOk        = optMod[0] && (aiCol < 3'(COLS)) &&
                  (optRow == 7'(counts_q[aiCol])) && (counts_q[aiCol] < 3'(ROWS));
    humanOk     = (bus.human_col < 3'(COLS)) && (counts_q[bus.human_col] < 3'(ROWS));
    moverColour = player_q ? AI : HUMAN;
    fallbackCol = '0;
    allFull     = 1'b1;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (counts_q[c] < 3'(ROWS)) fallbackCol = 3'(c);
      if (counts_q[c] != 3'(ROWS)) allFull = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    counts_d    = counts_q;
    player_d    = player_q;
    gameOver_d  = gameOver_q;
    winner_d    = winner_q;
    illegal_d   = 1'b0;
    doPlace     = 1'b0;
    placeCol    = bus.human_col;
    placeColour = moverColour;

    if (bus.new_game) begin
      state_d    = WAIT_HUMAN;
      player_d   = 1'b0;
      gameOver_d = 1'b0;
      winner_d   = EMPTY;
      for (int c = 0; c < COLS; c++) begin
        counts_d[c] = '0;
        for (int r = 0; r < ROWS; r++) cells_d[c][r] = EMPTY;
      end
    end else begin
      unique case (state_q)
        WAIT_HUMAN: begin
          if (bus.human_valid) begin
            if (humanOk) begin doPlace = 1'b1; state_d = SCAN; end
            else illegal_d = 1'b1;
          end
        end
        WAIT_AI: begin
          if (bus.sw) begin
            if (bus.move) begin
              doPlace = 1'b1;
              state_d = SCAN;
              if (aiOk) placeCol = aiCol;
              else begin placeCol = fallbackCol; illegal_d = 1'b1; end
            end
          end else if (bus.human_valid) begin
            if (humanOk) begin doPlace = 1'b1; state_d = SCAN; end
            else illegal_d = 1'b1;
          end
        end
        SCAN: begin
          // player still names the mover here, so it flips only once the scan resolves.
          if (scanHit) begin
            winner_d   = moverColour;
            gameOver_d = 1'b1;
            state_d    = OVER;
            player_d   = ~player_q;
          end else if (scanDone) begin
            player_d = ~player_q;
            if (allFull) begin
              gameOver_d = 1'b1;
              winner_d   = EMPTY;
              state_d    = OVER;
            end else begin
              state_d = player_q ? WAIT_HUMAN : WAIT_AI;
            end
          end
        end
        default: ;
      endcase
    end

    if (doPlace) begin
      cells_d[placeCol][counts_q[placeCol]] = placeColour;
      counts_d[placeCol] = counts_q[placeCol] + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_HUMAN;
      player_q   <= 1'b0;
      gameOver_q <= 1'b0;
      winner_q   <= EMPTY;
      illegal_q  <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        counts_q[c] <= '0;
        for (int r = 0; r < ROWS; r++) cells_q[c][r] <= EMPTY;
      end
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      gameOver_q <= gameOver_d;
      winner_q   <= winner_d;
      illegal_q  <= illegal_d;
      cells_q    <= cells_d;
      counts_q   <= counts_d;
    end
  end

  win_scan u_win_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .grid   (gridPacked),
    .colour (moverColour),
    .start  (state_q == SCAN),
    .hit    (scanHit),
    .done   (scanDone)
  );

  for (genvar c = 0; c < COLS; c++) begin : g_pack_col
    assign bus.column_counts[3*c+2 -: 3] = counts_q[c];
    for (genvar r = 0; r < ROWS; r++) begin : g_pack_row
      assign gridPacked[cellMsb(c, r) -: 2] = cells_q[c][r];
    end
  end

  assign bus.grid      = gridPacked;
  assign bus.player    = player_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.game_over = gameOver_q;
  assign bus.winner    = winner_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_connect4_board.sv
// Directed bench for connect4_board: a table of single drops plus hand-written
// win, full-column, new_game and mid-scan reset sequences.
module tb_connect4_board;
  import connect4_board_pkg::*;

  typedef struct {
    bit          hv;
    logic [2:0]  col;
    bit          mv;
    logic [6:0]  op;
    bit          expIllegal;
    int          expCol;
    logic [1:0]  expColour;
    int          expScan;
    logic [20:0] expCounts;
    bit          expPlayer;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [1:0] mBoard [7][6];
  int         mCount [7];

  connect4_board_if bus ();

  connect4_board dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 7; c++) begin
      mCount[c] = 0;
      for (int r = 0; r < 6; r++) mBoard[c][r] = 2'b00;
    end
  endtask

  task automatic modelPlace(input int col, input logic [1:0] colour);
    mBoard[col][mCount[col]] = colour;
    mCount[col]++;
  endtask

  function automatic logic [83:0] modelGrid();
    logic [83:0] g = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        g |= 84'(mBoard[c][r]) << (cellMsb(c, r) - 1);
    return g;
  endfunction

  function automatic logic [20:0] modelCounts();
    logic [20:0] cnt = '0;
    for (int c = 0; c < 7; c++) cnt |= 21'(mCount[c]) << (3 * c);
    return cnt;
  endfunction

  task automatic applyStimulus(input bit hv, input logic [2:0] col, input bit mv, input logic [6:0] op, input bit ng);
    @(negedge clk);
    bus.human_valid = hv;
    bus.human_col   = col;
    bus.move        = mv;
    bus.opt         = op;
    bus.new_game    = ng;
    @(negedge clk);
    bus.human_valid = 1'b0;
    bus.move        = 1'b0;
    bus.new_game    = 1'b0;
  endtask

  task automatic waitScan(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkBoard(input string tag);
    checkOutput({tag, " grid"}, bus.grid, modelGrid());
    checkOutput({tag, " counts"}, bus.column_counts, modelCounts());
  endtask

  initial begin : main
    vec_t vecs [10];
    int   n;

    vecs[0] = '{1'b1, 3'd3, 1'b0, 7'd0,  1'b0,  3, 2'b01, 69, 21'h00200, 1'b1};
    vecs[1] = '{1'b0, 3'd0, 1'b1, 7'd13, 1'b0,  0, 2'b10, 69, 21'h00201, 1'b0};
    vecs[2] = '{1'b1, 3'd5, 1'b0, 7'd0,  1'b0,  5, 2'b01, 69, 21'h08201, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 1'b1, 7'd1,  1'b0,  6, 2'b10, 69, 21'h48201, 1'b0};
    vecs[4] = '{1'b1, 3'd7, 1'b0, 7'd0,  1'b1, -1, 2'b00,  0, 21'h48201, 1'b0};
    vecs[5] = '{1'b1, 3'd4, 1'b0, 7'd0,  1'b0,  4, 2'b01, 69, 21'h49201, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 1'b1, 7'd2,  1'b1,  0, 2'b10, 69, 21'h49202, 1'b0};
    vecs[7] = '{1'b1, 3'd1, 1'b1, 7'd9,  1'b0,  1, 2'b01, 69, 21'h4920A, 1'b1};
    vecs[8] = '{1'b1, 3'd6, 1'b1, 7'd9,  1'b0,  2, 2'b10, 69, 21'h4924A, 1'b0};
    vecs[9] = '{1'b0, 3'd0, 1'b1, 7'd17, 1'b0, -1, 2'b00,  0, 21'h4924A, 1'b0};

    bus.sw = 1'b0; bus.new_game = 1'b0; bus.human_valid = 1'b0;
    bus.human_col = 3'd0; bus.move = 1'b0; bus.opt = 7'd0;
    rst_n = 1'b0;
    modelReset();
    #23;
    checkOutput("reset grid", bus.grid, 84'd0);
    checkOutput("reset counts", bus.column_counts, 21'd0);
    checkOutput("reset player", bus.player, 1'b0);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset game_over", bus.game_over, 1'b0);
    checkOutput("reset winner", bus.winner, 2'b00);
    checkOutput("reset illegal", bus.illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sw = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].hv, vecs[i].col, vecs[i].mv, vecs[i].op, 1'b0);
      checkOutput($sformatf("vec%0d illegal", i), bus.illegal, vecs[i].expIllegal);
      if (vecs[i].expCol >= 0) modelPlace(vecs[i].expCol, vecs[i].expColour);
      waitScan(n);
      checkOutput($sformatf("vec%0d scan cycles", i), n, vecs[i].expScan);
      checkOutput($sformatf("vec%0d grid", i), bus.grid, modelGrid());
      checkOutput($sformatf("vec%0d counts", i), bus.column_counts, vecs[i].expCounts);
      checkOutput($sformatf("vec%0d player", i), bus.player, vecs[i].expPlayer);
    end

    // Human stacks column 0 while the AI stacks column 1; the fourth human piece wins.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b1, 3'd0, 1'b0, 7'd0, 1'b0);
        modelPlace(0, 2'b01);
      end else begin
        applyStimulus(1'b0, 3'd0, 1'b1, 7'(11 + 14 * (i / 2)), 1'b0);
        modelPlace(1, 2'b10);
      end
      waitScan(n);
      checkOutput($sformatf("win seq move%0d scan cycles", i), n, (i == 6) ? 25 : 69);
    end
    checkOutput("win winner", bus.winner, 2'b01);
    checkOutput("win game_over", bus.game_over, 1'b1);
    checkBoard("win");

    applyStimulus(1'b1, 3'd5, 1'b0, 7'd0, 1'b0);
    checkOutput("over human busy", bus.busy, 1'b0);
    checkOutput("over human illegal", bus.illegal, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1, 7'd17, 1'b0);
    checkOutput("over move busy", bus.busy, 1'b0);
    checkBoard("over frozen");
    checkOutput("over game_over sticky", bus.game_over, 1'b1);
    checkOutput("over winner sticky", bus.winner, 2'b01);

    applyStimulus(1'b0, 3'd0, 1'b0, 7'd0, 1'b1);
    modelReset();
    checkBoard("new_game");
    checkOutput("new_game game_over", bus.game_over, 1'b0);
    checkOutput("new_game winner", bus.winner, 2'b00);
    checkOutput("new_game player", bus.player, 1'b0);

    applyStimulus(1'b1, 3'd3, 1'b0, 7'd0, 1'b1);
    checkOutput("new_game beats move busy", bus.busy, 1'b0);
    checkBoard("new_game beats move");

    applyStimulus(1'b1, 3'd3, 1'b0, 7'd0, 1'b0);
    modelPlace(3, 2'b01);
    checkOutput("post new_game busy", bus.busy, 1'b1);
    checkOutput("scan player holds mover", bus.player, 1'b0);
    waitScan(n);
    checkOutput("post new_game scan cycles", n, 69);
    checkOutput("post new_game player", bus.player, 1'b1);

    // Two-human mode: fill column 2, then a seventh drop there is rejected.
    applyStimulus(1'b0, 3'd0, 1'b0, 7'd0, 1'b1);
    modelReset();
    bus.sw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'd2, 1'b0, 7'd0, 1'b0);
      modelPlace(2, (i % 2 == 0) ? 2'b01 : 2'b10);
      waitScan(n);
      checkOutput($sformatf("fill col2 move%0d scan cycles", i), n, 69);
      if (i == 0) begin
        applyStimulus(1'b0, 3'd0, 1'b1, 7'd11, 1'b0);
        checkOutput("sw0 move ignored busy", bus.busy, 1'b0);
        checkOutput("sw0 move ignored illegal", bus.illegal, 1'b0);
        checkBoard("sw0 move ignored");
      end
    end
    checkOutput("col2 count full", bus.column_counts[8:6], 3'd6);
    checkOutput("col2 top cell", bus.grid[79:78], 2'b10);
    applyStimulus(1'b1, 3'd2, 1'b0, 7'd0, 1'b0);
    checkOutput("full col illegal", bus.illegal, 1'b1);
    checkOutput("full col busy", bus.busy, 1'b0);
    checkOutput("full col count", bus.column_counts[8:6], 3'd6);
    checkOutput("full col player", bus.player, 1'b0);
    @(negedge clk);
    checkOutput("illegal one cycle", bus.illegal, 1'b0);
    checkBoard("full col");

    // Asynchronous reset landing in the middle of a scan.
    applyStimulus(1'b0, 3'd0, 1'b0, 7'd0, 1'b1);
    modelReset();
    bus.sw = 1'b1;
    applyStimulus(1'b1, 3'd0, 1'b0, 7'd0, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("mid-scan busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset grid", bus.grid, 84'd0);
    checkOutput("async reset counts", bus.column_counts, 21'd0);
    checkOutput("async reset busy", bus.busy, 1'b0);
    checkOutput("async reset player", bus.player, 1'b0);
    checkOutput("async reset game_over", bus.game_over, 1'b0);
    checkOutput("async reset winner", bus.winner, 2'b00);
    checkOutput("async reset illegal", bus.illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("after reset winner", bus.winner, 2'b00);
    checkOutput("after reset busy", bus.busy, 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0, 7'd0, 1'b0);
    modelPlace(4, 2'b01);
    waitScan(n);
    checkOutput("after reset scan cycles", n, 69);
    checkBoard("after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
